sign_mul_seq: RTL



---
 rtl/cpu54_muldiv_pkg.sv | 15 +
 rtl/sign_mul_seq_if.sv | 29 ++
 rtl/sign_mul_seq_abs_cond.sv | 16 +
 rtl/sign_mul_seq.sv | 104 ++++++++++
 4 files changed

// File: rtl/cpu54_muldiv_pkg.sv
// Shared definitions for the CPU54 HI/LO multiply/divide execute unit.
package cpu54_muldiv_pkg;

  // Default operand width of the HI/LO datapath
  localparam int unsigned MUL_WIDTH = 32;

  // One shift-add iteration per operand bit
  localparam int unsigned ITER = MUL_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : cpu54_muldiv_pkg

// File: rtl/sign_mul_seq_if.sv
// Request/result bundle between the issue logic and the sequential multiplier.
interface sign_mul_seq_if
  import cpu54_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Requester side
  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo
  );

  // Multiplier side
  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo
  );

endinterface : sign_mul_seq_if

// File: rtl/sign_mul_seq_abs_cond.sv
// Conditional two's-complement magnitude: |val| when en and val is negative, else val.
// The magnitude is read as unsigned, so the most negative value maps onto itself.
module abs_cond
  import cpu54_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic             en,
  output logic [WIDTH-1:0] res
);

  // Negate only negative values in signed mode
  assign res = (en && val[WIDTH-1]) ? WIDTH'(~val + WIDTH'(1)) : val;

endmodule : abs_cond

// File: rtl/sign_mul_seq.sv
// Iterative 32x32 MULT/MULTU: sign-magnitude, one shift-add step per clock,
// 64-bit product delivered on hi/lo with a one-cycle done pulse.
module sign_mul_seq
  import cpu54_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk_in,
  input  logic          reset,
  sign_mul_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    step_c;
  logic [PW-1:0]    result_c;

  // Operand magnitudes for signed mode, raw operands otherwise
  abs_cond #(.WIDTH(WIDTH)) u_abs_a (
    .val (bus.op_a),
    .en  (bus.is_signed),
    .res (mag_a_c)
  );

  abs_cond #(.WIDTH(WIDTH)) u_abs_b (
    .val (bus.op_b),
    .en  (bus.is_signed),
    .res (mag_b_c)
  );

  // Single adder: add the multiplicand when the current multiplier bit is set
  assign sum_c = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};

  // Shift {carry, sum, multiplier} right by one; multiplier LSBs fill with product bits
  assign step_c = {sum_c, mplier[WIDTH-1:1]};

  // Restore the sign of the final product
  assign result_c = neg ? PW'(~step_c + PW'(1)) : step_c;

  // Control FSM and datapath registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            mcand  <= mag_a_c;
            mplier <= mag_b_c;
            acc_hi <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc_hi <= step_c[PW-1:WIDTH];
          mplier <= step_c[WIDTH-1:0];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi_q   <= result_c[PW-1:WIDTH];
            lo_q   <= result_c[WIDTH-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule : sign_mul_seq
